// File: rtl/csa_accum_pkg.sv
// Shared definitions for the carry-save accumulator: FSM states, accumulator
// width derivation and operand extension.
package csa_accum_pkg;

  typedef enum logic [1:0] {
    ACC = 2'd0,
    RES = 2'd1,
    OUT = 2'd2
  } state_t;

  // Widest operand the extend() helper can carry; callers truncate to AW.
  localparam int EXT_MAX = 64;

  function automatic int acc_width(input int dw, input int cw);
    return dw + cw;
  endfunction

  // Bits at and above dw are copies of bit dw-1 when sgn, zeros otherwise.
  function automatic logic [EXT_MAX-1:0] extend(input logic [EXT_MAX-1:0] v,
                                                input int dw, input bit sgn);
    logic [EXT_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < EXT_MAX; i++) begin
      r[i] = (i < dw) ? v[i] : (sgn & v[dw-1]);
    end
    return r;
  endfunction

endpackage

// File: rtl/csa_accum_if.sv
// Operand stream in and resolved-result stream out of the carry-save
// accumulator, both valid/ready.
interface csa_accum_if #(
  parameter int DW = 16,
  parameter int CW = 4
);
  localparam int AW = csa_accum_pkg::acc_width(DW, CW);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_cnt;
  logic          out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

endinterface

// File: rtl/csa_compress.sv
// Bitwise 3:2 compressor: three W-bit words in, sum and unshifted carry out.
module csa_compress #(
  parameter int W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] cy
);

  assign s  = a ^ b ^ c;
  assign cy = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accum.sv
// Carry-save operand accumulator: one operand per cycle in redundant form,
// one carry-propagate add per group, result on a valid/ready port.
module csa_accum
  import csa_accum_pkg::*;
#(
  parameter int DW     = 16,
  parameter int CW     = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        clr,
  csa_accum_if.slave  bus
);

  localparam int AW = acc_width(DW, CW);

  state_t        state, state_nxt;
  logic [AW-1:0] s_reg, c_reg, x;
  logic [AW-2:0] s_lo, cy_lo;
  logic          s_msb;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          accept;
  logic          cnt_full;
  logic [AW-1:0] sum_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;

  assign x = AW'(extend(EXT_MAX'(bus.in_data), DW, SIGNED));

  // The carry out of the top bit would shift beyond AW and is dropped, so only
  // the lower AW-1 bit positions need a full compressor.
  csa_compress #(.W(AW-1)) u_csa (
    .a  (s_reg[AW-2:0]),
    .b  (c_reg[AW-2:0]),
    .c  (x[AW-2:0]),
    .s  (s_lo),
    .cy (cy_lo)
  );

  assign s_msb = s_reg[AW-1] ^ c_reg[AW-1] ^ x[AW-1];

  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == OUT);
  assign bus.out_sum   = sum_q;
  assign bus.out_cnt   = cnt_q;
  assign bus.out_ovf   = ovf_q;

  assign accept   = bus.in_valid & bus.in_ready & ~clr;
  assign cnt_full = &cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && bus.in_last) state_nxt = RES;
      RES:     state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
    if (clr) state_nxt = ACC;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ACC;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s_reg <= '0;
      c_reg <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      sum_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      s_reg <= '0;
      c_reg <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            s_reg <= {s_msb, s_lo};
            c_reg <= {cy_lo, 1'b0};
            if (cnt_full) ovf <= 1'b1;
            else          cnt <= cnt + 1'b1;
          end
        end
        RES: begin
          sum_q <= s_reg + c_reg;
          cnt_q <= cnt;
          ovf_q <= ovf;
        end
        OUT: begin
          if (bus.out_ready) begin
            s_reg <= '0;
            c_reg <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
